// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared ALU.
// The arbiter uses the slave modport; the requester/ALU side uses master.
interface alu_arbiter_if #(
  parameter int SIZE = 16
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2:0]      req_op0;
  logic [2:0]      req_op1;
  logic [SIZE-1:0] req_a0;
  logic [SIZE-1:0] req_b0;
  logic [SIZE-1:0] req_a1;
  logic [SIZE-1:0] req_b1;
  logic [1:0]      req_flagwr;

  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [SIZE-1:0] rsp_result;
  logic [3:0]      rsp_flags;
  logic            rsp_err;

  logic [SIZE-1:0] alu_a;
  logic [SIZE-1:0] alu_b;
  logic [2:0]      alu_ctrl;
  logic [SIZE-1:0] alu_result;
  logic [3:0]      alu_flags;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
           req_flagwr, rsp_ready, alu_result, alu_flags,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err,
           alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
           req_flagwr, rsp_ready, alu_result, alu_flags,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err,
           alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared ALU: accepts one op,
// drives the ALU for a cycle, returns result/flags and owns the flags register.
module alu_arbiter #(
  parameter int SIZE = 16
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic [3:0]   flags_q
);

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic            last_grant_q;
  logic            id_q;
  logic            flagwr_q;
  logic [SIZE-1:0] alu_a_q;
  logic [SIZE-1:0] alu_b_q;
  logic [2:0]      alu_ctrl_q;
  logic [SIZE-1:0] rsp_result_q;
  logic [3:0]      rsp_flags_q;
  logic            rsp_err_q;
  logic [1:0]      rsp_valid_q;

  logic            gnt_valid_d;
  logic            gnt_id_d;
  logic [2:0]      sel_op_d;
  logic [SIZE-1:0] sel_a_d;
  logic [SIZE-1:0] sel_b_d;
  logic            sel_fw_d;

  // Grant decision in IDLE; a tie goes to the requester that did not win last.
  always_comb begin
    gnt_valid_d = 1'b0;
    gnt_id_d    = 1'b0;
    if (state_q == IDLE) begin
      case (bus.req_valid)
        2'b01: begin
          gnt_valid_d = 1'b1;
          gnt_id_d    = 1'b0;
        end
        2'b10: begin
          gnt_valid_d = 1'b1;
          gnt_id_d    = 1'b1;
        end
        2'b11: begin
          gnt_valid_d = 1'b1;
          gnt_id_d    = ~last_grant_q;
        end
        default: begin
          gnt_valid_d = 1'b0;
          gnt_id_d    = 1'b0;
        end
      endcase
    end else begin
      gnt_valid_d = 1'b0;
      gnt_id_d    = 1'b0;
    end
  end

  // Request fields of the granted requester.
  always_comb begin
    if (gnt_id_d) begin
      sel_op_d = bus.req_op1;
      sel_a_d  = bus.req_a1;
      sel_b_d  = bus.req_b1;
      sel_fw_d = bus.req_flagwr[1];
    end else begin
      sel_op_d = bus.req_op0;
      sel_a_d  = bus.req_a0;
      sel_b_d  = bus.req_b0;
      sel_fw_d = bus.req_flagwr[0];
    end
  end

  assign bus.req_ready = gnt_valid_d ? (gnt_id_d ? 2'b10 : 2'b01) : 2'b00;

  // Transaction FSM: accept, one ALU cycle, hold response until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      flagwr_q     <= 1'b0;
      alu_a_q      <= {SIZE{1'b0}};
      alu_b_q      <= {SIZE{1'b0}};
      alu_ctrl_q   <= 3'b000;
      rsp_result_q <= {SIZE{1'b0}};
      rsp_flags_q  <= 4'b0000;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 2'b00;
      flags_q      <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid_d) begin
            alu_ctrl_q   <= sel_op_d;
            alu_a_q      <= sel_a_d;
            alu_b_q      <= sel_b_d;
            flagwr_q     <= sel_fw_d;
            id_q         <= gnt_id_d;
            last_grant_q <= gnt_id_d;
            state_q      <= EXEC;
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          // An illegal opcode returns zeros and never touches the flags register.
          if (alu_ctrl_q == OP_ILLEGAL) begin
            rsp_result_q <= {SIZE{1'b0}};
            rsp_flags_q  <= 4'b0000;
            rsp_err_q    <= 1'b1;
          end else begin
            rsp_result_q <= bus.alu_result;
            rsp_flags_q  <= bus.alu_flags;
            rsp_err_q    <= 1'b0;
            if (flagwr_q) begin
              flags_q <= bus.alu_flags;
            end else begin
              flags_q <= flags_q;
            end
          end
          rsp_valid_q <= id_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[id_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_valid  = rsp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, vector table,
// directed corner sequences and a randomized transaction-level model.
module tb_alu_arbiter;
  localparam int SIZE = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] flags_q;
  int         checks = 0;
  int         errors = 0;

  alu_arbiter_if #(.SIZE(SIZE)) bus();

  alu_arbiter #(.SIZE(SIZE)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .flags_q (flags_q)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {N,Z,C,V, result}; opcode 111 yields junk on purpose.
  function automatic logic [19:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int ua, ub, sa, sb, s;
    logic [15:0] r;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; r = 16'h0000;
    case (op)
      3'd0: begin s = ua + ub; c = (s > 65535); v = ((sa + sb) > 32767) || ((sa + sb) < -32768); r = s[15:0]; end
      3'd1: begin s = ua - ub; c = (ua >= ub); v = ((sa - sb) > 32767) || ((sa - sb) < -32768); r = s[15:0]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = b;
      default: return {4'hF, a ^ b ^ 16'hDEAD};
    endcase
    return {r[15], (r == 16'h0000), c, v, r};
  endfunction

  logic [19:0] alu_out;
  assign alu_out        = alu_ref(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  assign bus.alu_result = alu_out[15:0];
  assign bus.alu_flags  = alu_out[19:16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic id, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic fw);
    if (id) begin
      bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; bus.req_flagwr[1] = fw;
    end else begin
      bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; bus.req_flagwr[0] = fw;
    end
  endtask

  function automatic logic [15:0] rnd_operand();
    logic [15:0] corner [5];
    corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        fw;
    logic [15:0] res;
    logic [3:0]  fl;
    logic        err;
    logic [3:0]  fq;
  } vec_t;

  vec_t vecs [11];

  // random-phase state
  logic [1:0]  pend;
  logic [2:0]  p_op [2];
  logic [15:0] p_a [2];
  logic [15:0] p_b [2];
  logic        p_fw [2];
  logic        lg, win;
  logic [3:0]  m_flags, e_fl;
  logic [15:0] e_res;
  logic        e_err;
  logic [19:0] rf;
  logic [1:0]  own;

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1001, 1'b0, 4'b1001};
    vecs[1]  = '{1'b1, 3'b111, 16'h1234, 16'h5678, 1'b1, 16'h0000, 4'b0000, 1'b1, 4'b1001};
    vecs[2]  = '{1'b0, 3'b001, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b0110, 1'b0, 4'b1001};
    vecs[3]  = '{1'b1, 3'b011, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 4'b0000, 1'b0, 4'b1001};
    vecs[4]  = '{1'b0, 3'b110, 16'h0000, 16'hA5A5, 1'b1, 16'hA5A5, 4'b1000, 1'b0, 4'b1000};
    vecs[5]  = '{1'b1, 3'b010, 16'hFF00, 16'h0FF0, 1'b1, 16'h0F00, 4'b0000, 1'b0, 4'b0000};
    vecs[6]  = '{1'b0, 3'b100, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 4'b0100, 1'b0, 4'b0100};
    vecs[7]  = '{1'b1, 3'b101, 16'h00FF, 16'h1234, 1'b0, 16'hFF00, 4'b1000, 1'b0, 4'b0100};
    vecs[8]  = '{1'b0, 3'b000, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b0110, 1'b0, 4'b0110};
    vecs[9]  = '{1'b1, 3'b001, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b1000, 1'b0, 4'b1000};
    vecs[10] = '{1'b0, 3'b001, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0011, 1'b0, 4'b0011};

    reset = 1'b1;
    bus.req_valid = 2'b00; bus.req_flagwr = 2'b00; bus.rsp_ready = 2'b11;
    set_req(1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
    set_req(1'b1, 3'b000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset rsp_result", 32'(bus.rsp_result), 32'h0);
    chk("reset rsp_flags", 32'(bus.rsp_flags), 32'h0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("reset alu_a", 32'(bus.alu_a), 32'h0);
    chk("reset alu_b", 32'(bus.alu_b), 32'h0);
    chk("reset alu_ctrl", 32'(bus.alu_ctrl), 32'h0);
    chk("reset flags_q", 32'(flags_q), 32'h0);
    chk("reset req_ready idle", 32'(bus.req_ready), 32'h0);

    // Table: single-requester operations with fixed 3-cycle timing
    for (int i = 0; i < 11; i++) begin
      set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fw);
      bus.req_valid = vecs[i].id ? 2'b10 : 2'b01;
      #1;
      chk($sformatf("vec%0d req_ready", i), 32'(bus.req_ready), 32'(bus.req_valid));
      tick();
      bus.req_valid = 2'b00;
      #1;
      chk($sformatf("vec%0d exec rsp_valid", i), 32'(bus.rsp_valid), 32'h0);
      chk($sformatf("vec%0d alu_ctrl", i), 32'(bus.alu_ctrl), 32'(vecs[i].op));
      tick();
      chk($sformatf("vec%0d rsp_valid", i), 32'(bus.rsp_valid), vecs[i].id ? 32'h2 : 32'h1);
      chk($sformatf("vec%0d result", i), 32'(bus.rsp_result), 32'(vecs[i].res));
      chk($sformatf("vec%0d flags", i), 32'(bus.rsp_flags), 32'(vecs[i].fl));
      chk($sformatf("vec%0d err", i), 32'(bus.rsp_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d flags_q", i), 32'(flags_q), 32'(vecs[i].fq));
      tick();
    end

    // Reset during EXEC of a flag-writing ADD (flags_q is 0011 beforehand)
    set_req(1'b0, 3'b000, 16'h7FFF, 16'h0001, 1'b1);
    bus.req_valid = 2'b01;
    #1;
    chk("rstexec req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rstexec no rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rstexec flags_q", 32'(flags_q), 32'h0);
      chk("rstexec idle req_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.req_valid = 2'b11;
    #1;
    chk("rstexec tie grants 0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Both requesters continuously valid: grants alternate
    set_req(1'b0, 3'b001, 16'h0005, 16'h0005, 1'b0);
    set_req(1'b1, 3'b011, 16'h00F0, 16'h0F00, 1'b0);
    bus.req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("alt%0d grant", g), 32'(bus.req_ready), (g % 2) ? 32'h2 : 32'h1);
      tick();
      chk($sformatf("alt%0d exec req_ready", g), 32'(bus.req_ready), 32'h0);
      tick();
      chk($sformatf("alt%0d rsp_valid", g), 32'(bus.rsp_valid), (g % 2) ? 32'h2 : 32'h1);
      chk($sformatf("alt%0d result", g), 32'(bus.rsp_result), (g % 2) ? 32'h0FF0 : 32'h0000);
      chk($sformatf("alt%0d flags", g), 32'(bus.rsp_flags), (g % 2) ? 32'h0 : 32'h6);
      chk($sformatf("alt%0d flags_q", g), 32'(flags_q), 32'h0);
      tick();
    end
    bus.req_valid = 2'b00;

    // Back-pressure on requester 0 while requester 1 waits
    set_req(1'b0, 3'b000, 16'h1234, 16'h1111, 1'b0);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b10;
    #1;
    chk("bp grant0", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(1'b1, 3'b100, 16'h00FF, 16'h0F0F, 1'b0);
    bus.req_valid = 2'b10;
    #1;
    chk("bp exec req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp%0d rsp_valid", k), 32'(bus.rsp_valid), 32'h1);
      chk($sformatf("bp%0d result", k), 32'(bus.rsp_result), 32'h2345);
      chk($sformatf("bp%0d req_ready", k), 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.rsp_ready = 2'b11;
    #1;
    chk("bp release rsp_valid", 32'(bus.rsp_valid), 32'h1);
    tick();
    chk("bp grant1 after release", 32'(bus.req_ready), 32'h2);
    chk("bp idle rsp_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("bp req1 rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("bp req1 result", 32'(bus.rsp_result), 32'h0FF0);
    tick();

    // Randomized transactions against a transaction-level model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lg = 1'b1; m_flags = 4'b0000; pend = 2'b00;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          p_op[i] = 3'($urandom_range(0, 7));
          p_a[i] = rnd_operand(); p_b[i] = rnd_operand();
          p_fw[i] = 1'($urandom_range(0, 1));
          set_req(1'(i), p_op[i], p_a[i], p_b[i], p_fw[i]);
        end
      end
      bus.req_valid = pend;
      bus.rsp_ready = 2'($urandom_range(0, 3));
      #1;
      if (pend == 2'b00) begin
        chk("rnd idle req_ready", 32'(bus.req_ready), 32'h0);
        tick();
        continue;
      end
      win = (pend == 2'b11) ? ~lg : pend[1];
      own = win ? 2'b10 : 2'b01;
      chk("rnd grant", 32'(bus.req_ready), 32'(own));
      rf = alu_ref(p_op[win], p_a[win], p_b[win]);
      if (p_op[win] == 3'b111) begin
        e_res = 16'h0000; e_fl = 4'b0000; e_err = 1'b1;
      end else begin
        e_res = rf[15:0]; e_fl = rf[19:16]; e_err = 1'b0;
        if (p_fw[win]) m_flags = e_fl;
      end
      tick();
      pend[win] = 1'b0;
      lg = win;
      if (!pend[~win] && $urandom_range(0, 1) == 1) begin
        pend[~win] = 1'b1;
        p_op[~win] = 3'($urandom_range(0, 7));
        p_a[~win] = rnd_operand(); p_b[~win] = rnd_operand();
        p_fw[~win] = 1'($urandom_range(0, 1));
        set_req(~win, p_op[~win], p_a[~win], p_b[~win], p_fw[~win]);
      end
      bus.req_valid = pend;
      #1;
      chk("rnd exec req_ready", 32'(bus.req_ready), 32'h0);
      tick();
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        bus.rsp_ready = 2'($urandom_range(0, 3)) & ~own;
        #1;
        chk("rnd stall rsp_valid", 32'(bus.rsp_valid), 32'(own));
        chk("rnd stall result", 32'(bus.rsp_result), 32'(e_res));
        chk("rnd stall req_ready", 32'(bus.req_ready), 32'h0);
        tick();
      end
      bus.rsp_ready = 2'($urandom_range(0, 3)) | own;
      #1;
      chk("rnd rsp_valid", 32'(bus.rsp_valid), 32'(own));
      chk("rnd result", 32'(bus.rsp_result), 32'(e_res));
      chk("rnd flags", 32'(bus.rsp_flags), 32'(e_fl));
      chk("rnd err", 32'(bus.rsp_err), 32'(e_err));
      chk("rnd flags_q", 32'(flags_q), 32'(m_flags));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
